// File: rtl/button_debouncer.sv
// N-channel push-button debouncer sampled on every edge of a slow tick, with registered level/press/release.
// Optional auto-repeat of btn_press while held is enabled by defining BUTTON_DEBOUNCER_REPEAT_EN.
module button_debouncer #(
  parameter int N_BUTTONS      = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_PERIOD  = 5
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 tick_in,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_CHECK_HIGH  = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_CHECK_LOW   = 2'd3
  } state_t;

  localparam logic [3:0] L_STABLE = 4'(STABLE_SAMPLES);

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = ($clog2(REP_MAX + 1) > 5) ? $clog2(REP_MAX + 1) : 5;
  localparam logic [REP_W-1:0] L_DELAY  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] L_PERIOD = REP_W'(REPEAT_PERIOD);
  localparam logic [REP_W-1:0] L_ONE    = REP_W'(1);
`endif

  if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 15 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_debouncer: illegal parameter value");
  end

  logic [N_BUTTONS-1:0] r_sync1;
  logic [N_BUTTONS-1:0] r_sync2;
  logic                 r_tick_q;
  logic                 w_strobe;

  assign w_strobe = tick_in ^ r_tick_q;

  // Two-flop synchronizer for the raw buttons and the tick edge detector.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_tick_q <= 1'b0;
    end else begin
      r_sync1  <= btn_raw;
      r_sync2  <= r_sync1;
      r_tick_q <= tick_in;
    end
  end

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_level, w_level_nxt;
    logic       r_press, w_press_nxt;
    logic       r_release, w_release_nxt;
    logic       w_sync;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    logic [REP_W-1:0] r_rep, w_rep_nxt, w_rep_inc, w_rep_tgt;
    logic             r_rep_arm, w_rep_arm_nxt;

    assign w_rep_inc = r_rep + L_ONE;
    assign w_rep_tgt = r_rep_arm ? L_PERIOD : L_DELAY;
`endif

    assign w_sync = r_sync2[g];

    // Next-state and pulse generation; everything holds unless a strobe is present.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      w_rep_nxt     = r_rep;
      w_rep_arm_nxt = r_rep_arm;
`endif
      if (w_strobe) begin
        case (r_state)
          ST_STABLE_LOW: begin
            if (w_sync) begin
              w_state_nxt = ST_CHECK_HIGH;
              w_cnt_nxt   = 4'd1;
            end else begin
              w_cnt_nxt   = 4'd0;
            end
          end
          ST_CHECK_HIGH: begin
            if (!w_sync) begin
              w_state_nxt = ST_STABLE_LOW;
              w_cnt_nxt   = 4'd0;
            end else if (r_cnt + 4'd1 >= L_STABLE) begin
              w_state_nxt = ST_STABLE_HIGH;
              w_cnt_nxt   = 4'd0;
              w_level_nxt = 1'b1;
              w_press_nxt = 1'b1;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
              w_rep_nxt     = '0;
              w_rep_arm_nxt = 1'b0;
`endif
            end else begin
              w_cnt_nxt   = r_cnt + 4'd1;
            end
          end
          ST_STABLE_HIGH: begin
            if (!w_sync) begin
              w_state_nxt = ST_CHECK_LOW;
              w_cnt_nxt   = 4'd1;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
              w_rep_nxt     = '0;
              w_rep_arm_nxt = 1'b0;
`endif
            end else begin
              w_cnt_nxt   = 4'd0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
              // First repeat after the delay, later ones every period.
              if (w_rep_inc >= w_rep_tgt) begin
                w_press_nxt   = 1'b1;
                w_rep_nxt     = '0;
                w_rep_arm_nxt = 1'b1;
              end else begin
                w_rep_nxt     = w_rep_inc;
              end
`endif
            end
          end
          ST_CHECK_LOW: begin
            if (w_sync) begin
              w_state_nxt = ST_STABLE_HIGH;
              w_cnt_nxt   = 4'd0;
            end else if (r_cnt + 4'd1 >= L_STABLE) begin
              w_state_nxt   = ST_STABLE_LOW;
              w_cnt_nxt     = 4'd0;
              w_level_nxt   = 1'b0;
              w_release_nxt = 1'b1;
            end else begin
              w_cnt_nxt     = r_cnt + 4'd1;
            end
          end
          default: begin
            w_state_nxt = ST_STABLE_LOW;
            w_cnt_nxt   = 4'd0;
            w_level_nxt = 1'b0;
          end
        endcase
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end

    // Per-channel state, counter and registered outputs.
    always_ff @(posedge clk_in) begin
      if (!reset) begin
        r_state   <= ST_STABLE_LOW;
        r_cnt     <= 4'd0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        r_rep     <= '0;
        r_rep_arm <= 1'b0;
`endif
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        r_rep     <= w_rep_nxt;
        r_rep_arm <= w_rep_arm_nxt;
`endif
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: a run-length reference model predicts pulses, a monitor checks them.
module tb_button_debouncer;
  localparam int N = 4;
  localparam int S = 4;
  localparam int D = 25;
  localparam int P = 5;

  logic         clk_in = 1'b0;
  logic         reset = 1'b0;
  logic         tick_in = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  button_debouncer #(
    .N_BUTTONS(N), .STABLE_SAMPLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  bit tick_run = 1'b1;

  // tick_in toggles every 10 cycles while enabled
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk_in);
      if (tick_run) begin
        if (div == 9) begin
          div = 0;
          tick_in = ~tick_in;
        end else begin
          div++;
        end
      end
    end
  end

  // Reference model: the level flips once S consecutive samples disagree with it.
  typedef struct {
    longint       cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } ev_t;
  ev_t          exp_q[$];
  longint       cyc = 0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] raw_d1 = '0;
  logic [N-1:0] raw_d2 = '0;
  logic         tick_prev = 1'b0;
  int           m_run[N];
  int           m_hold[N];
  logic [N-1:0] ep, er;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_hold[i] = 0;
    end
    forever begin
      @(posedge clk_in);
      cyc++;
      if (!reset) begin
        m_level = '0;
        raw_d1 = '0;
        raw_d2 = '0;
        tick_prev = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_run[i] = 0;
          m_hold[i] = 0;
        end
      end else begin
        ep = '0;
        er = '0;
        if (tick_in != tick_prev) begin
          for (int i = 0; i < N; i++) begin
            if (raw_d2[i] != m_level[i]) begin
              m_run[i]++;
              m_hold[i] = 0;
              if (m_run[i] == S) begin
                m_level[i] = raw_d2[i];
                m_run[i] = 0;
                if (raw_d2[i]) ep[i] = 1'b1;
                else er[i] = 1'b1;
              end
            end else begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
              if (m_level[i] && m_run[i] == 0) begin
                m_hold[i]++;
                if (m_hold[i] >= D && (m_hold[i] - D) % P == 0) ep[i] = 1'b1;
              end
`endif
              m_run[i] = 0;
            end
          end
        end
        tick_prev = tick_in;
        raw_d2 = raw_d1;
        raw_d1 = btn_raw;
        if ((ep | er) != '0) exp_q.push_back('{cyc, ep, er});
      end
    end
  end

  // Monitor: compares level every cycle and pops an expectation whenever a pulse is due or seen.
  int     press_cnt[N];
  int     rel_cnt[N];
  longint rel_cyc[N];
  ev_t    e;

  initial begin
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
      rel_cyc[i] = 0;
    end
    @(posedge clk_in);
    forever begin
      @(negedge clk_in);
      n_cmp++;
      if (btn_level !== m_level) begin
        n_err++;
        $display("FAIL level cyc=%0d actual=%b required=%b", cyc, btn_level, m_level);
      end
      if (exp_q.size() > 0 || (btn_press | btn_release) !== '0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
        end else begin
          e.cyc = cyc;
          e.press = '0;
          e.rel = '0;
        end
        n_cmp++;
        if (btn_press !== e.press || btn_release !== e.rel || e.cyc != cyc) begin
          n_err++;
          $display("FAIL pulse cyc=%0d actual press=%b release=%b required press=%b release=%b at cyc=%0d",
                   cyc, btn_press, btn_release, e.press, e.rel, e.cyc);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (btn_press[i] === 1'b1) press_cnt[i]++;
        if (btn_release[i] === 1'b1) begin
          rel_cnt[i]++;
          rel_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  function automatic int total_pulses();
    int t;
    t = 0;
    for (int i = 0; i < N; i++) t += press_cnt[i] + rel_cnt[i];
    return t;
  endfunction

  int p0, p2, r1, r3, tp, k, rep_req;

  initial begin
    // reset then idle
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(200);
    check("idle_level", int'(btn_level), 0);
    check("idle_pulses", total_pulses(), 0);

    // clean press on bit 0
    p0 = press_cnt[0];
    btn_raw[0] = 1'b1;
    cycles(80);
    check("press_b0_count", press_cnt[0] - p0, 1);
    check("press_b0_level", int'(btn_level), 1);
    check("press_other_bits", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    btn_raw[0] = 1'b0;
    cycles(80);
    check("release_b0_count", rel_cnt[0], 1);

    // bounce 1,0,1 across three strobes, then hold
    p0 = press_cnt[0];
    btn_raw[0] = 1'b1;
    cycles(10);
    btn_raw[0] = 1'b0;
    cycles(10);
    btn_raw[0] = 1'b1;
    cycles(80);
    check("bounce_press_count", press_cnt[0] - p0, 1);
    btn_raw[0] = 1'b0;
    cycles(80);

    // simultaneous release on bits 1 and 3
    btn_raw = 4'b1010;
    cycles(80);
    check("b13_level_high", int'(btn_level), 10);
    r1 = rel_cnt[1];
    r3 = rel_cnt[3];
    btn_raw = 4'b0000;
    cycles(80);
    check("b1_release_count", rel_cnt[1] - r1, 1);
    check("b3_release_count", rel_cnt[3] - r3, 1);
    check("b13_same_edge", int'(rel_cyc[1]), int'(rel_cyc[3]));

    // reset after three high strobes discards the partial count
    p2 = press_cnt[2];
    btn_raw[2] = 1'b1;
    k = 0;
    while (m_run[2] != 3 && k < 200) begin
      cycles(1);
      k++;
    end
    check("midcheck_reached", int'(k < 200), 1);
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    check("midcheck_no_press", press_cnt[2] - p2, 0);
    check("midcheck_level", int'(btn_level), 0);
    cycles(30);
    check("midcheck_fresh_wait", press_cnt[2] - p2, 0);
    cycles(30);
    check("midcheck_press_after", press_cnt[2] - p2, 1);
    btn_raw[2] = 1'b0;
    cycles(80);

    // long hold on bit 2: 40 strobes past the press
    p2 = press_cnt[2];
    btn_raw[2] = 1'b1;
    k = 0;
    while (press_cnt[2] == p2 && k < 200) begin
      cycles(1);
      k++;
    end
    check("hold_first_press", press_cnt[2] - p2, 1);
    cycles(405);
    btn_raw[2] = 1'b0;
    cycles(80);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    rep_req = 5;
`else
    rep_req = 1;
`endif
    check("hold_press_total", press_cnt[2] - p2, rep_req);

    // frozen tick: raw activity must not move anything
    tick_run = 1'b0;
    tp = total_pulses();
    for (int s = 0; s < 10; s++) begin
      btn_raw = 4'($urandom_range(15, 0));
      cycles(15);
    end
    check("freeze_no_pulses", total_pulses() - tp, 0);
    check("freeze_level", int'(btn_level), 0);
    tick_run = 1'b1;
    cycles(100);

    // randomized glitches, holds and occasional resets
    for (int s = 0; s < 80; s++) begin
      btn_raw[$urandom_range(N - 1, 0)] = 1'($urandom_range(1, 0));
      if ($urandom_range(19, 0) == 0) begin
        reset = 1'b0;
        cycles(int'($urandom_range(3, 1)));
        reset = 1'b1;
      end
      cycles(int'($urandom_range(80, 1)));
    end
    btn_raw = '0;
    cycles(120);
    check("final_level", int'(btn_level), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
